// File: rtl/gb_video_pkg.sv
// Shared DMG video definitions: LCD geometry, pixel shade type and the
// framebuffer writer state encoding.
package gb_video_pkg;
  localparam int LCD_W        = 160;
  localparam int LCD_H        = 144;
  localparam int PIX_PER_BYTE = 4;

  typedef logic [1:0] gb_color_t;

  typedef enum logic [1:0] {WAIT_VS, ACTIVE, DONE} fbw_state_t;
endpackage

// File: rtl/pix_packer.sv
// Packs 2-bit pixels four to a byte (pixel 0 in the LSBs). Emits a byte when
// the fourth slot fills or when a line end flushes a partial byte; a frame
// restart throws away whatever is pending.
module pix_packer
  import gb_video_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  gb_color_t i_color,
  input  logic      i_flush,
  input  logic      i_discard,
  output logic [7:0] o_byte,
  output logic      o_valid
);
  logic [1:0] r_slot;
  logic [7:0] r_pack;
  logic [7:0] w_merged;
  logic       w_full;

  // Merge the incoming pixel so a full or flushed byte can leave this cycle
  always_comb begin
    w_merged = r_pack;
    if (i_push) w_merged[2*r_slot +: 2] = i_color;
    w_full  = i_push && (r_slot == 2'd3);
    // A flush only writes when at least one slot holds a pixel of this line;
    // a pixel landing in slot 3 alongside the flush is covered by w_full
    o_valid = !i_discard && (w_full || (i_flush && (i_push || (r_slot != 2'd0))));
    o_byte  = w_merged;
  end

  // Slot counter and pack register; any emit, line end or discard restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= 2'd0;
      r_pack <= 8'd0;
    end else if (i_discard || i_flush || o_valid) begin
      r_slot <= 2'd0;
      r_pack <= 8'd0;
    end else if (i_push) begin
      r_slot <= r_slot + 2'd1;
      r_pack <= w_merged;
    end
  end
endmodule

// File: rtl/ppu_fb_writer.sv
// PPU pixel stream to framebuffer byte writer. Tracks x/y, aligns frames on
// vsync rise, packs pixels via pix_packer and drives registered write strobes.
// Optional debug counters are built when PPU_FB_WRITER_STATS_EN is defined.
module ppu_fb_writer
  import gb_video_pkg::*;
#(
  parameter int WIDTH  = LCD_W,
  parameter int HEIGHT = LCD_H,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ppu_vs,
  input  logic              ppu_hs,
  input  logic              ppu_de,
  input  gb_color_t         ppu_color,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [7:0]        fb_wdata,
  output logic              frame_done,
  output logic              overflow
`ifdef PPU_FB_WRITER_STATS_EN
  ,
  output logic [15:0]       dbg_frames,
  output logic [7:0]        dbg_short_lines
`endif
);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0]     X_END     = XW'(WIDTH);
  localparam logic [YW-1:0]     Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(WIDTH / PIX_PER_BYTE);

  fbw_state_t          r_state, w_next_state;
  logic                r_vs_prev, r_hs_prev;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [ADDR_W-1:0]   r_line_base;
  logic                w_vs_rise, w_hs_rise;
  logic                w_push, w_eol, w_frame_end, w_ovf_set;
  logic [7:0]          w_pk_byte;
  logic                w_pk_valid;

  assign w_vs_rise = ppu_vs & ~r_vs_prev;
  assign w_hs_rise = ppu_hs & ~r_hs_prev;

  // Edge-detect history for vsync/hsync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_hs_prev <= 1'b0;
    end else begin
      r_vs_prev <= ppu_vs;
      r_hs_prev <= ppu_hs;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_VS;
    else        r_state <= w_next_state;
  end

  // FSM next state: vsync rise restarts a frame from any state
  always_comb begin
    w_next_state = r_state;
    if (w_vs_rise)
      w_next_state = ACTIVE;
    else if ((r_state == ACTIVE) && w_hs_rise && (r_y == Y_LAST))
      w_next_state = DONE;
  end

  // FSM outputs: vsync beats every same-cycle pixel or line event
  always_comb begin
    w_push      = (r_state == ACTIVE) && ppu_de && !w_vs_rise && (r_x < X_END);
    w_eol       = (r_state == ACTIVE) && w_hs_rise && !w_vs_rise;
    w_frame_end = w_eol && (r_y == Y_LAST);
    w_ovf_set   = ppu_de && !w_vs_rise &&
                  (((r_state == ACTIVE) && (r_x == X_END)) || (r_state == DONE));
  end

  // Position counters; line_base steps by a row of bytes to avoid a multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_line_base <= '0;
    end else if (w_vs_rise) begin
      r_x         <= '0;
      r_y         <= '0;
      r_line_base <= '0;
    end else if (w_eol) begin
      r_x         <= '0;
      r_y         <= r_y + 1'b1;
      r_line_base <= r_line_base + ROW_BYTES;
    end else if (w_push) begin
      r_x <= r_x + 1'b1;
    end
  end

  pix_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_color   (ppu_color),
    .i_flush   (w_eol),
    .i_discard (w_vs_rise),
    .o_byte    (w_pk_byte),
    .o_valid   (w_pk_valid)
  );

  // Registered write port and status; x/4 is the byte being filled or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we      <= 1'b0;
      fb_waddr   <= '0;
      fb_wdata   <= 8'd0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      fb_we      <= w_pk_valid;
      frame_done <= w_frame_end;
      if (w_pk_valid) begin
        fb_waddr <= r_line_base + ADDR_W'(r_x >> 2);
        fb_wdata <= w_pk_byte;
      end
      if (w_vs_rise)      overflow <= 1'b0;
      else if (w_ovf_set) overflow <= 1'b1;
    end
  end

`ifdef PPU_FB_WRITER_STATS_EN
  logic [XW-1:0] w_x_after;
  assign w_x_after = r_x + XW'(w_push);

  // Debug counters survive vsync; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_frames      <= 16'd0;
      dbg_short_lines <= 8'd0;
    end else begin
      if (w_frame_end) dbg_frames <= dbg_frames + 16'd1;
      if (w_eol && (w_x_after != '0) && (w_x_after < X_END) && (dbg_short_lines != 8'hFF))
        dbg_short_lines <= dbg_short_lines + 8'd1;
    end
  end
`endif
endmodule
